// File: rtl/tt_checker.sv
// Exhaustive response checker: walks every input vector, waits SETTLE cycles,
// samples the DUT response and scores it against a truth table.
module tt_checker #(
    parameter int                   N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hD5,
    parameter int                   SETTLE   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] first_fail_q;
    logic [CW-1:0]   cnt_q;
    logic [N_IN:0]   err_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic            fail_valid_q;

    logic            mismatch_d;
    logic [N_IN:0]   err_d;
    logic            last_vec_d;

    // err_d already includes the comparison on the current sample edge, so the
    // final pass decision sees the last vector's result.
    assign mismatch_d = resp ^ EXPECTED[vec_q];
    assign err_d      = err_q + {{N_IN{1'b0}}, mismatch_d};
    assign last_vec_d = &vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        vec_q        <= '0;
                        cnt_q        <= CNT_INIT;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (mismatch_d) begin
                            err_q <= err_d;
                            if (!fail_valid_q) begin
                                first_fail_q <= vec_q;
                                fail_valid_q <= 1'b1;
                            end
                        end
                        if (!last_vec_d) begin
                            vec_q <= vec_q + 1'b1;
                            cnt_q <= CNT_INIT;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            vec_q   <= '0;
                            pass_q  <= (err_d == '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_tt_checker.sv
// Directed bench for tt_checker: default 3-input configuration plus a
// 2-input, SETTLE=1 instance, each fed by a selectable response model.
module tb_tt_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] vec;
    logic       resp;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] first_fail;

    logic       start2;
    logic [1:0] vec2;
    logic       resp2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [2:0] err_count2;
    logic [1:0] first_fail2;

    int mode;   // 0 correct, 1 tied high, 2 inverted
    int mode2;  // 0 AND, 1 OR
    int n_checks;
    int n_fail;

    tt_checker dut (
        .clk(clk), .rst(rst), .start(start), .vec(vec), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );

    tt_checker #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .vec(vec2), .resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_valid(fail_valid2), .first_fail(first_fail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        resp = ~vec[0] | (vec[2] & vec[1]);
        if (mode == 1) resp = 1'b1;
        else if (mode == 2) resp = ~(~vec[0] | (vec[2] & vec[1]));
        resp2 = (mode2 == 1) ? (vec2[1] | vec2[0]) : (vec2[1] & vec2[0]);
    end

    task automatic test_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if ({busy, done, pass, fail_valid, err_count, vec, first_fail} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got busy=%b done=%b pass=%b fv=%b err=%0d vec=%0d ff=%0d, want all 0",
                     busy, done, pass, fail_valid, err_count, vec, first_fail);
        end
        n_checks++;
        if ({busy2, done2, pass2, fail_valid2, err_count2, vec2, first_fail2} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: got busy=%b done=%b pass=%b fv=%b err=%0d vec=%0d ff=%0d, want all 0",
                     busy2, done2, pass2, fail_valid2, err_count2, vec2, first_fail2);
        end
    endtask

    // Full run on the default instance; optional extra start at E0+5.
    task automatic run_default(input string name, input int m, input bit restart_mid,
                               input int exp_err, input int exp_ff, input bit exp_fv,
                               input bit exp_pass);
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;   // E0
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (restart_mid && e == 4) start = 1'b1;
            if (e == 5) start = 1'b0;
            if (e < 16) begin
                n_checks++;
                if (vec !== 3'(e / 2) || busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_step%0d: got vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
                             name, e, vec, busy, done, e / 2);
                end
            end else begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || vec !== 3'd0) begin
                    n_fail++;
                    $display("FAIL %s_done: got done=%b busy=%b vec=%0d at E0+16, want 1 0 0",
                             name, done, busy, vec);
                end
            end
        end
        n_checks++;
        if (err_count !== 4'(exp_err) || first_fail !== 3'(exp_ff) ||
            fail_valid !== exp_fv || pass !== exp_pass) begin
            n_fail++;
            $display("FAIL %s_result: got err=%0d ff=%0d fv=%b pass=%b, want err=%0d ff=%0d fv=%b pass=%b",
                     name, err_count, first_fail, fail_valid, pass, exp_err, exp_ff, exp_fv, exp_pass);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || err_count !== 4'(exp_err) || pass !== exp_pass) begin
            n_fail++;
            $display("FAIL %s_hold: got done=%b err=%0d pass=%b, want done=1 err=%0d pass=%b",
                     name, done, err_count, pass, exp_err, exp_pass);
        end
        $display("run %s: err=%0d first_fail=%0d fail_valid=%b pass=%b", name, err_count,
                 first_fail, fail_valid, pass);
    endtask

    task automatic test_correct();
        run_default("correct", 0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_tied_high();
        run_default("tied_high", 1, 1'b0, 3, 1, 1'b1, 1'b0);
    endtask

    task automatic test_inverted();
        run_default("inverted", 2, 1'b0, 8, 0, 1'b1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_default("restart_mid", 0, 1'b1, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid_run();
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;   // E0
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;                     // sampled at E0+7
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || vec !== 3'd0 || err_count !== 4'd0 || done !== 1'b0 ||
            fail_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b vec=%0d err=%0d done=%b fv=%b, want 0 0 0 0 0",
                     busy, vec, err_count, done, fail_valid);
        end
        $display("rst mid-run: busy=%b vec=%0d err=%0d", busy, vec, err_count);
        run_default("after_rst", 0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic run_small(input string name, input int m, input int exp_err,
                             input int exp_ff, input bit exp_fv, input bit exp_pass);
        mode2 = m;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;  // E0
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (e < 4 && (vec2 !== 2'(e) || done2 !== 1'b0)) begin
                n_fail++;
                $display("FAIL %s_step%0d: got vec=%0d done=%b, want vec=%0d done=0",
                         name, e, vec2, done2, e);
            end else if (e == 4 && (done2 !== 1'b1 || busy2 !== 1'b0)) begin
                n_fail++;
                $display("FAIL %s_done: got done=%b busy=%b at E0+4, want 1 0", name, done2, busy2);
            end
        end
        n_checks++;
        if (err_count2 !== 3'(exp_err) || first_fail2 !== 2'(exp_ff) ||
            fail_valid2 !== exp_fv || pass2 !== exp_pass) begin
            n_fail++;
            $display("FAIL %s_result: got err=%0d ff=%0d fv=%b pass=%b, want err=%0d ff=%0d fv=%b pass=%b",
                     name, err_count2, first_fail2, fail_valid2, pass2, exp_err, exp_ff, exp_fv, exp_pass);
        end
        $display("run %s: err=%0d first_fail=%0d pass=%b", name, err_count2, first_fail2, pass2);
    endtask

    task automatic test_small_config();
        run_small("small_and", 0, 0, 0, 1'b0, 1'b1);
        run_small("small_or", 1, 2, 1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        mode = 0; mode2 = 0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_correct();
        test_tied_high();
        test_inverted();
        test_start_while_busy();
        test_rst_mid_run();
        test_small_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_checker.md
Name: tt_checker

Overview:
- Self-checking exhaustive response checker for small combinational blocks; the receiving and checking end of a stimulus/response pair.
- Walks every N_IN-bit input vector in ascending order and drives it to the DUT on `vec`.
- Waits SETTLE cycles per vector, samples the DUT's single-bit response and compares it against a parameterised truth table.
- Reports mismatch count, first failing vector and pass/fail. Used on-chip or in benches to replace hand-written display/monitor checking.

Parameters:
- N_IN, 3, number of DUT inputs; vector space is 2^N_IN.
- EXPECTED, 8'hD5, expected truth table, width 2^N_IN; bit i is the expected response for vec==i. The default encodes f = ~c | a&b with vec = {a,b,c}.
- SETTLE, 2, cycles each vector is held before its response is sampled; legal values are 1 and above.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE
- vec  out  N_IN  stimulus vector to DUT inputs
- resp  in  1  DUT response
- busy  out  1  high while a run is in progress
- done  out  1  high from end of run until next accepted start or rst
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  N_IN+1  number of mismatching vectors in the run
- fail_valid  out  1  high once any mismatch is recorded in the run
- first_fail  out  N_IN  vector index of the first mismatch; 0 when fail_valid==0

Behaviour:
- Reset, checked at the clock edge with rst high and having priority over everything: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - state<=RUN, busy<=1, done<=0, pass<=0, err_count<=0, fail_valid<=0, first_fail<=0, vec<=0, settle counter<=SETTLE-1.
- RUN, each edge:
  - If the counter is nonzero, decrement it; vec is held.
  - If the counter is 0, this is a sample edge:
    - Compare resp with EXPECTED[vec].
    - On mismatch, err_count<=err_count+1. If fail_valid==0, also first_fail<=vec and fail_valid<=1.
    - If vec != 2^N_IN-1: vec<=vec+1 and counter<=SETTLE-1.
    - Otherwise (last vector): state<=DONE, busy<=0, done<=1, vec<=0, and pass<=1 iff the final error count is 0, including the comparison made on this edge.
- Timing:
  - Vector k is applied at edge E0+k*SETTLE and sampled at edge E0+(k+1)*SETTLE.
  - done rises at edge E0+2^N_IN*SETTLE; 16 edges with default parameters.
- start while busy is ignored and has no effect on state or results.
- Results (pass, err_count, fail_valid, first_fail) hold in DONE until the next accepted start or rst.
- err_count cannot overflow: its maximum value is 2^N_IN, which fits in N_IN+1 bits.
- vec never wraps during a run; the run terminates at the all-ones vector.
- rst mid-run aborts immediately to the reset state; partial results are discarded.
- The settle counter is clog2(SETTLE) bits wide, minimum 1 bit. With SETTLE=1 every RUN edge is a sample edge.

Test Plan:
- rst, then start; resp = ~vec[0] | vec[2]&vec[1] (correct model). Required: vec steps 0..7, each held 2 cycles; done at E0+16; pass=1, err_count=0, fail_valid=0.
- resp tied to 1. Required: mismatches at vectors 1, 3, 5; err_count=3, first_fail=1, fail_valid=1, pass=0.
- resp = inverted model. Required: err_count=8, first_fail=0, fail_valid=1, pass=0.
- start pulsed again at E0+5 mid-run. Required: ignored; done still at E0+16 with the same results as the first scenario.
- rst pulsed at E0+7. Required: next cycle busy=0, vec=0, err_count=0, done=0. A new start then gives a clean 16-cycle run with pass=1.
- N_IN=2, SETTLE=1, EXPECTED=4'b1000, resp = vec[1]&vec[0]. Required: done at E0+4, pass=1. Repeating with resp=vec[1]|vec[0] gives err_count=2 and first_fail=1.
